// File: rtl/axi_lite_master_ctrl.sv
// axi_lite_master_ctrl: single-outstanding AXI4-Lite master sequencer with cmd/rsp handshakes and a hang watchdog
module axi_lite_master_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WVALID,
    input  logic                    WREADY,
    output logic                    BREADY,
    input  logic                    BVALID,
    input  logic [1:0]              BRESP,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    output logic                    RREADY,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic                    RVALID,
    input  logic [1:0]              RRESP
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, hs, aw_done, w_done, active, expire;
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign b_hs    = BREADY && BVALID;
    assign ar_hs   = ARVALID && ARREADY;
    assign r_hs    = RREADY && RVALID;
    assign hs      = aw_hs || w_hs || b_hs || ar_hs || r_hs;
    // a dropped VALID inside WR_ADDR_DATA means that channel already completed
    assign aw_done = !AWVALID || AWREADY;
    assign w_done  = !WVALID || WREADY;
    assign active  = state inside {WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA};
    assign expire  = (TIMEOUT != 0) && active && !hs && (cnt == CW'(TIMEOUT - 1));
    assign busy    = state != IDLE;
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state       <= IDLE;
            cnt         <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= 2'b00;
            rsp_timeout <= 1'b0;
            AWADDR      <= '0;
            AWVALID     <= 1'b0;
            WDATA       <= '0;
            WSTRB       <= '0;
            WVALID      <= 1'b0;
            BREADY      <= 1'b0;
            ARADDR      <= '0;
            ARVALID     <= 1'b0;
            RREADY      <= 1'b0;
        end else begin
            cnt <= (hs || !active) ? '0 : cnt + 1'b1;
            if (expire) begin
                state       <= RSP;
                AWVALID     <= 1'b0;
                WVALID      <= 1'b0;
                BREADY      <= 1'b0;
                ARVALID     <= 1'b0;
                RREADY      <= 1'b0;
                rsp_valid   <= 1'b1;
                rsp_write   <= state inside {WR_ADDR_DATA, WR_RESP};
                rsp_rdata   <= '0;
                rsp_resp    <= 2'b10;
                rsp_timeout <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        cmd_ready <= !(cmd_valid && cmd_ready);
                        if (cmd_valid && cmd_ready && cmd_write) begin
                            state   <= WR_ADDR_DATA;
                            AWADDR  <= cmd_addr;
                            WDATA   <= cmd_wdata;
                            WSTRB   <= cmd_wstrb;
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                        end else if (cmd_valid && cmd_ready) begin
                            state   <= RD_ADDR;
                            ARADDR  <= cmd_addr;
                            ARVALID <= 1'b1;
                        end
                    end
                    WR_ADDR_DATA: begin
                        if (aw_hs) AWVALID <= 1'b0;
                        if (w_hs) WVALID <= 1'b0;
                        if (aw_done && w_done) begin
                            state  <= WR_RESP;
                            BREADY <= 1'b1;
                            cnt    <= '0;
                        end
                    end
                    WR_RESP: if (b_hs) begin
                        state       <= RSP;
                        BREADY      <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_write   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_resp    <= BRESP;
                        rsp_timeout <= 1'b0;
                    end
                    RD_ADDR: if (ar_hs) begin
                        state   <= RD_DATA;
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        cnt     <= '0;
                    end
                    RD_DATA: if (r_hs) begin
                        state       <= RSP;
                        RREADY      <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_write   <= 1'b0;
                        rsp_rdata   <= RDATA;
                        rsp_resp    <= RRESP;
                        rsp_timeout <= 1'b0;
                    end
                    default: if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// tb_axi_lite_master_ctrl: table-driven, randomized and directed checks of axi_lite_master_ctrl
module tb_axi_lite_master_ctrl;
    logic ACLK = 1'b0, ARESETn = 1'b0;
    logic cmd_valid = 0, cmd_ready, cmd_write = 0;
    logic [3:0] cmd_addr = 0, cmd_wstrb = 0;
    logic [31:0] cmd_wdata = 0;
    logic rsp_valid, rsp_ready = 0, rsp_write, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic [1:0] rsp_resp;
    logic [3:0] AWADDR, ARADDR, WSTRB;
    logic [31:0] WDATA;
    logic AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic AWREADY = 0, WREADY = 0, BVALID = 0, ARREADY = 0, RVALID = 0;
    logic [1:0] BRESP = 0, RRESP = 0;
    logic [31:0] RDATA = 0;
    int n_cmp = 0, n_bad = 0;
    int aw_d, w_d, b_d, ar_d, r_d, aw_c, w_c, b_c, ar_c, r_c, n_aw, n_w, n_b, n_ar, n_r;
    logic [1:0] s_resp;
    logic [31:0] s_rdata, got_wdata;
    logic [3:0] got_awaddr, got_wstrb, got_araddr;
    logic [87:0] outs;
    assign outs = {cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout, busy, AWADDR, AWVALID,
                   WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY};

    axi_lite_master_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout), .busy(busy), .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY), .BREADY(BREADY), .BVALID(BVALID),
        .BRESP(BRESP), .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .RREADY(RREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RRESP(RRESP));

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    // slave: each READY/VALID is raised after the programmed number of waiting cycles and held one cycle
    initial forever begin
        @(negedge ACLK); #1;
        if (!ARESETn || AWREADY) AWREADY = 0;
        else if (AWVALID) begin
            if (aw_c == aw_d) begin AWREADY = 1; got_awaddr = AWADDR; n_aw++; aw_c = 0; end
            else aw_c++;
        end
    end
    initial forever begin
        @(negedge ACLK); #1;
        if (!ARESETn || WREADY) WREADY = 0;
        else if (WVALID) begin
            if (w_c == w_d) begin WREADY = 1; got_wdata = WDATA; got_wstrb = WSTRB; n_w++; w_c = 0; end
            else w_c++;
        end
    end
    initial forever begin
        @(negedge ACLK); #1;
        if (!ARESETn || BVALID) BVALID = 0;
        else if (BREADY) begin
            if (b_c == b_d) begin BVALID = 1; BRESP = s_resp; n_b++; b_c = 0; end
            else b_c++;
        end
    end
    initial forever begin
        @(negedge ACLK); #1;
        if (!ARESETn || ARREADY) ARREADY = 0;
        else if (ARVALID) begin
            if (ar_c == ar_d) begin ARREADY = 1; got_araddr = ARADDR; n_ar++; ar_c = 0; end
            else ar_c++;
        end
    end
    initial forever begin
        @(negedge ACLK); #1;
        if (!ARESETn || RVALID) RVALID = 0;
        else if (RREADY) begin
            if (r_c == r_d) begin RVALID = 1; RDATA = s_rdata; RRESP = s_resp; n_r++; r_c = 0; end
            else r_c++;
        end
    end

    // protocol monitor: VALID and payload held until handshake, VALID dropped after it
    initial begin
        logic pav, pwv, parv, prst;
        logic [3:0] paa, pws, para;
        logic [31:0] pwd;
        {pav, pwv, parv, prst, paa, pws, para, pwd} = '0;
        forever begin
            @(negedge ACLK);
            if (ARESETn && prst && !(rsp_valid && rsp_timeout)) begin
                if (pav) chk("aw_hold", 128'({AWVALID, AWADDR}), AWREADY ? 128'({1'b0, AWADDR}) : 128'({1'b1, paa}));
                if (pwv) chk("w_hold", 128'({WVALID, WDATA, WSTRB}), WREADY ? 128'({1'b0, WDATA, WSTRB}) : 128'({1'b1, pwd, pws}));
                if (parv) chk("ar_hold", 128'({ARVALID, ARADDR}), ARREADY ? 128'({1'b0, ARADDR}) : 128'({1'b1, para}));
                if (BREADY) chk("bready_after_aw_w", 128'(AWVALID | WVALID), 128'(0));
            end
            {pav, paa, pwv, pwd, pws, parv, para, prst} = {AWVALID, AWADDR, WVALID, WDATA, WSTRB, ARVALID, ARADDR, ARESETn};
        end
    end

    task automatic send(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input int hold,
                        output int lat, output logic r_wr, output logic [1:0] r_resp, output logic [31:0] r_data,
                        output logic r_to);
        int n = 0;
        logic cr = 0;
        @(negedge ACLK);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < 50) begin @(negedge ACLK); n++; end
        chk("cmd_accept", 128'(cmd_ready), 128'(1));
        @(posedge ACLK); #1 cmd_valid = 0;
        lat = 0;
        do begin @(negedge ACLK); lat++; end while (!rsp_valid && lat < 100);
        {r_wr, r_resp, r_data, r_to} = {rsp_write, rsp_resp, rsp_rdata, rsp_timeout};
        if (hold > 0) begin
            cmd_valid = 1; cmd_write = ~w; cmd_addr = ~a;
            repeat (hold) begin @(negedge ACLK); cr |= cmd_ready; end
            chk("rsp_hold", 128'({cr, rsp_valid, rsp_write, rsp_resp, rsp_rdata, rsp_timeout}),
                128'({1'b0, 1'b1, r_wr, r_resp, r_data, r_to}));
            cmd_valid = 0;
        end
        rsp_ready = 1;
        @(posedge ACLK); #1 rsp_ready = 0;
    endtask

    typedef struct {
        logic w; logic [3:0] a; logic [31:0] d; logic [3:0] s;
        int awd, wd, bd, ard, rd, hold;
        logic [1:0] sr; logic [31:0] srd;
        int lat; logic [1:0] resp; logic [31:0] rdata; logic to;
    } vec_t;

    task automatic apply(input vec_t v);
        int lat;
        logic r_wr, r_to;
        logic [1:0] r_resp;
        logic [31:0] r_data;
        {aw_d, w_d, b_d, ar_d, r_d} = {v.awd, v.wd, v.bd, v.ard, v.rd};
        {aw_c, w_c, b_c, ar_c, r_c, n_aw, n_w, n_b, n_ar, n_r} = '0;
        {got_awaddr, got_wdata, got_wstrb, got_araddr} = '0;
        s_resp = v.sr; s_rdata = v.srd;
        send(v.w, v.a, v.d, v.s, v.hold, lat, r_wr, r_resp, r_data, r_to);
        chk("latency", 128'(lat), 128'(v.lat));
        chk("rsp", 128'({r_wr, r_resp, r_data, r_to}), 128'({v.w, v.resp, v.rdata, v.to}));
        if (!v.to && v.w)
            chk("bus_write", 128'({8'(n_aw), 8'(n_w), 8'(n_b), 8'(n_ar), got_awaddr, got_wdata, got_wstrb}),
                128'({8'd1, 8'd1, 8'd1, 8'd0, v.a, v.d, v.s}));
        if (!v.to && !v.w)
            chk("bus_read", 128'({8'(n_ar), 8'(n_r), 8'(n_aw), 8'(n_w), got_araddr}),
                128'({8'd1, 8'd1, 8'd0, 8'd0, v.a}));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[10];
        vec_t v;
        int n;
        logic rv;
        //        w     a      d             s     awd   wd bd    ard   rd hold sr     srd            lat resp   rdata          to
        tbl[0] = '{1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 0,    0, 0,    0,    0, 0,   2'b00, 32'h0,         3,  2'b00, 32'h0,         1'b0};
        tbl[1] = '{1'b1, 4'h6, 32'hCAFEF00D, 4'h3, 4,    1, 0,    0,    0, 0,   2'b01, 32'h0,         7,  2'b01, 32'h0,         1'b0};
        tbl[2] = '{1'b0, 4'h8, 32'h0,        4'h0, 0,    0, 0,    0,    5, 0,   2'b10, 32'h12345678,  8,  2'b10, 32'h12345678,  1'b0};
        tbl[3] = '{1'b0, 4'h3, 32'h0,        4'h0, 0,    0, 0,    1000, 0, 0,   2'b00, 32'hFFFFFFFF,  17, 2'b10, 32'h0,         1'b1};
        tbl[4] = '{1'b1, 4'h2, 32'h11112222, 4'h5, 2,    0, 3,    0,    0, 0,   2'b11, 32'h0,         8,  2'b11, 32'h0,         1'b0};
        tbl[5] = '{1'b1, 4'hA, 32'h0F0F0F0F, 4'hC, 5,    5, 0,    0,    0, 10,  2'b00, 32'h0,         8,  2'b00, 32'h0,         1'b0};
        tbl[6] = '{1'b1, 4'hC, 32'h55AA55AA, 4'h0, 1000, 0, 0,    0,    0, 0,   2'b00, 32'h0,         18, 2'b10, 32'h0,         1'b1};
        tbl[7] = '{1'b1, 4'hE, 32'h77777777, 4'h9, 0,    0, 1000, 0,    0, 0,   2'b01, 32'h0,         18, 2'b10, 32'h0,         1'b1};
        tbl[8] = '{1'b0, 4'hF, 32'h0,        4'h0, 0,    0, 0,    15,   0, 0,   2'b01, 32'hA5A50001,  18, 2'b01, 32'hA5A50001, 1'b0};
        tbl[9] = '{1'b0, 4'h0, 32'h0,        4'h0, 0,    0, 0,    2,    3, 2,   2'b00, 32'h0BADC0DE,  8,  2'b00, 32'h0BADC0DE,  1'b0};
        repeat (3) @(negedge ACLK);
        chk("reset_outputs", 128'(outs), 128'(0));
        ARESETn = 1;
        foreach (tbl[i]) apply(tbl[i]);
        for (int i = 0; i < 40; i++) begin
            v.w = 1'($urandom); v.a = 4'($urandom); v.d = $urandom; v.s = 4'($urandom);
            v.awd = $urandom_range(0, 8); v.wd = $urandom_range(0, 8); v.bd = $urandom_range(0, 8);
            v.ard = $urandom_range(0, 8); v.rd = $urandom_range(0, 8); v.hold = $urandom_range(0, 3);
            v.sr = 2'($urandom); v.srd = $urandom;
            v.lat = v.w ? 3 + (v.awd > v.wd ? v.awd : v.wd) + v.bd : 3 + v.ard + v.rd;
            v.resp = v.sr; v.rdata = v.w ? 32'h0 : v.srd; v.to = 1'b0;
            apply(v);
        end
        // reset pulsed while waiting for the write response
        {aw_d, w_d, b_d, aw_c, w_c, b_c} = {0, 0, 1000, 0, 0, 0};
        @(negedge ACLK);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h5; cmd_wdata = 32'h13572468; cmd_wstrb = 4'hF;
        @(posedge ACLK); #1 cmd_valid = 0;
        n = 0;
        while (!BREADY && n < 20) begin @(negedge ACLK); n++; end
        chk("wr_resp_reached", 128'(BREADY), 128'(1));
        #2 ARESETn = 0;
        #1 chk("async_reset_outputs", 128'(outs), 128'(0));
        repeat (2) @(negedge ACLK);
        ARESETn = 1;
        rv = 0;
        repeat (5) begin @(negedge ACLK); rv |= rsp_valid; end
        chk("post_reset_idle", 128'({rv, busy, cmd_ready}), 128'({1'b0, 1'b0, 1'b1}));
        apply(tbl[0]);
        apply(tbl[2]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
